// File: rtl/reg_write_scoreboard.sv
// Register write scoreboard: tracks pending scalar/vector register writes,
// blocks RAW/WAW hazards at issue and emits fixed-latency writeback strobes.
module reg_write_scoreboard #(
  parameter int REG_ADDR_W  = 4,
  parameter int WB_LAT      = 3,
  parameter int VEC_OP_MIN  = 12,
  parameter int LOAD_S_CODE = 0,
  parameter int LOAD_V_CODE = 15
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           issue_valid,
  input  logic [1:0]                     op_type,
  input  logic [3:0]                     op_code,
  input  logic [REG_ADDR_W-1:0]          rd,
  input  logic [REG_ADDR_W-1:0]          rs1,
  input  logic [REG_ADDR_W-1:0]          rs2,
  input  logic                           rs_vec,
  input  logic                           flush,
  output logic                           issue_ready,
  output logic                           stall,
  output logic                           wb_we,
  output logic                           wb_we_v,
  output logic [REG_ADDR_W-1:0]          wb_rd,
  output logic [2**REG_ADDR_W-1:0]       busy_s,
  output logic [2**REG_ADDR_W-1:0]       busy_v,
  output logic [$clog2(WB_LAT+1)-1:0]    pending_cnt
);

  localparam int NREG  = 2**REG_ADDR_W;
  localparam int CNT_W = $clog2(WB_LAT+1);
  localparam logic [NREG-1:0] NOT_REG0 = {{(NREG-1){1'b1}}, 1'b0};

  logic isScalar;
  logic isVector;
  logic hazard;
  logic acceptS;
  logic acceptV;
  logic acceptW;
  logic wbActive;

  logic [WB_LAT-1:0]                 stgWe;
  logic [WB_LAT-1:0]                 stgWeV;
  logic [WB_LAT-1:0][REG_ADDR_W-1:0] stgRd;

  logic [NREG-1:0] busyS;
  logic [NREG-1:0] busyV;
  logic [NREG-1:0] busySNext;
  logic [NREG-1:0] busyVNext;
  logic [NREG-1:0] rdHot;
  logic [NREG-1:0] wbHot;
  logic [NREG-1:0] srcBusy;
  logic [CNT_W-1:0] pendingCnt;
  logic [CNT_W-1:0] pendingNext;

  always_comb begin
    isScalar = 1'b0;
    isVector = 1'b0;
    if (rd != '0) begin
      if (!op_type[1]) begin
        if (int'(op_code) < VEC_OP_MIN) isScalar = 1'b1;
        else                            isVector = 1'b1;
      end else if (op_type == 2'b10) begin
        if (int'(op_code) == LOAD_S_CODE)      isScalar = 1'b1;
        else if (int'(op_code) == LOAD_V_CODE) isVector = 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_hot
      assign rdHot[gi] = (rd == REG_ADDR_W'(gi));
      assign wbHot[gi] = (stgRd[WB_LAT-1] == REG_ADDR_W'(gi));
    end
  endgenerate

  // The writeback stage keeps its register busy through its strobe cycle (no bypass).
  assign srcBusy = rs_vec ? busyV : busyS;
  assign hazard  = srcBusy[rs1] | srcBusy[rs2] |
                   (isScalar & busyS[rd]) | (isVector & busyV[rd]);

  assign issue_ready = issue_valid & ~hazard & ~flush;
  assign stall       = issue_valid & ~issue_ready;

  assign acceptS  = issue_ready & isScalar;
  assign acceptV  = issue_ready & isVector;
  assign acceptW  = acceptS | acceptV;
  assign wbActive = stgWe[WB_LAT-1] | stgWeV[WB_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stgWe  <= '0;
      stgWeV <= '0;
      stgRd  <= '0;
    end else if (flush) begin
      // The stage strobing now retires at this edge; everything younger is dropped.
      stgWe  <= '0;
      stgWeV <= '0;
      stgRd  <= '0;
    end else begin
      stgWe[0]  <= acceptS;
      stgWeV[0] <= acceptV;
      stgRd[0]  <= acceptW ? rd : '0;
      for (int i = 1; i < WB_LAT; i++) begin
        stgWe[i]  <= stgWe[i-1];
        stgWeV[i] <= stgWeV[i-1];
        stgRd[i]  <= stgRd[i-1];
      end
    end
  end

  always_comb begin
    logic [NREG-1:0] keepS;
    logic [NREG-1:0] keepV;
    logic [NREG-1:0] clrS;
    logic [NREG-1:0] clrV;
    logic [CNT_W-1:0] keepCnt;
    clrS  = stgWe[WB_LAT-1]  ? wbHot : '0;
    clrV  = stgWeV[WB_LAT-1] ? wbHot : '0;
    // Flush keeps only the writeback in progress, which then retires normally.
    keepS = flush ? (busyS & clrS) : busyS;
    keepV = flush ? (busyV & clrV) : busyV;
    busySNext = ((keepS & ~clrS) | (acceptS ? rdHot : '0)) & NOT_REG0;
    busyVNext = ((keepV & ~clrV) | (acceptV ? rdHot : '0)) & NOT_REG0;

    keepCnt = flush ? (wbActive ? CNT_W'(1) : '0) : pendingCnt;
    pendingNext = keepCnt;
    if (acceptW && !wbActive)      pendingNext = keepCnt + CNT_W'(1);
    else if (!acceptW && wbActive) pendingNext = keepCnt - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busyS      <= '0;
      busyV      <= '0;
      pendingCnt <= '0;
    end else begin
      busyS      <= busySNext;
      busyV      <= busyVNext;
      pendingCnt <= pendingNext;
    end
  end

  assign wb_we       = stgWe[WB_LAT-1];
  assign wb_we_v     = stgWeV[WB_LAT-1];
  assign wb_rd       = stgRd[WB_LAT-1];
  assign busy_s      = busyS;
  assign busy_v      = busyV;
  assign pending_cnt = pendingCnt;

endmodule

// File: doc/reg_write_scoreboard.md
REG_WRITE_SCOREBOARD -- requirements
Module: reg_write_scoreboard

Interface
REQ-001 SHALL provide parameter REG_ADDR_W, default 4: register address width; each file has 2**REG_ADDR_W registers.
REQ-002 SHALL provide parameter WB_LAT, default 3: cycles from issue acceptance to writeback pulse; legal range 1..8.
REQ-003 SHALL provide parameter VEC_OP_MIN, default 12: lowest ALU op_code that is a vector operation.
REQ-004 SHALL provide parameters LOAD_S_CODE, default 0, and LOAD_V_CODE, default 15: scalar and vector load op_codes.
REQ-005 SHALL have ports, one clock, reset asynchronous and active-low:
 clk  in  1  clock, rising edge
 rst_n  in  1  asynchronous active-low reset
 issue_valid  in  1  instruction presented for issue
 op_type  in  2  instruction class
 op_code  in  4  operation code
 rd  in  REG_ADDR_W  destination register
 rs1, rs2  in  REG_ADDR_W  source registers
 rs_vec  in  1  sources read from vector file
 flush  in  1  discard in-flight writes
 issue_ready  out  1  instruction accepted this cycle
 stall  out  1  issue_valid held off by hazard or flush
 wb_we  out  1  scalar register-file write strobe
 wb_we_v  out  1  vector register-file write strobe
 wb_rd  out  REG_ADDR_W  writeback destination
 busy_s  out  2**REG_ADDR_W  scalar registers with pending write
 busy_v  out  2**REG_ADDR_W  vector registers with pending write
 pending_cnt  out  clog2(WB_LAT+1)  in-flight writes

Function
REQ-006 SHALL decode write class combinationally: rd==0 -> none; op_type[1]==0 and op_code<VEC_OP_MIN -> scalar; op_type[1]==0 and op_code>=VEC_OP_MIN -> vector; op_type==2'b10 and op_code==LOAD_S_CODE -> scalar; op_type==2'b10 and op_code==LOAD_V_CODE -> vector; otherwise none.
REQ-007 SHALL treat register 0 of both files as never busy and never written.
REQ-008 SHALL flag hazard when busy bit of rs1 or rs2 is set in the file chosen by rs_vec (RAW), or busy bit of rd is set in the decoded destination file (WAW).
REQ-009 SHALL drive issue_ready = issue_valid & !hazard & !flush and stall = issue_valid & !issue_ready, both combinational.
REQ-010 SHALL enter an accepted instruction of class scalar or vector into a WB_LAT-stage shift pipeline (valid, class, rd); class none is accepted but occupies no stage.
REQ-011 SHALL set the destination busy bit at the acceptance edge; instruction accepted at edge E SHALL produce wb_we or wb_we_v high, with wb_rd=rd, for exactly the cycle after edge E+WB_LAT-1 (i.e., WB_LAT cycles later).
REQ-012 SHALL clear the busy bit at the edge ending the writeback cycle; no bypass: an issue reading that register during the writeback cycle stalls.
REQ-013 SHALL register wb_we, wb_we_v, wb_rd (last pipeline stage); wb_rd SHALL be 0 when neither strobe is high.
REQ-014 SHALL never assert wb_we and wb_we_v together.
REQ-015 SHALL increment pending_cnt on each accepted write, decrement on each writeback, hold when both occur same edge; never exceeds WB_LAT.
REQ-016 On flush at edge: SHALL invalidate all stages except the one currently driving writeback (it completes), clear all busy bits except that one's, and set pending_cnt to 1 if a writeback is in progress else 0.
REQ-017 SHALL leave the block stateless beyond pipeline, busy vectors and counter; no internal FSM other than pipeline valid bits.

Reset
REQ-018 SHALL, while rst_n low, asynchronously clear all pipeline valids, busy_s, busy_v, wb_we, wb_we_v, wb_rd, pending_cnt to 0.
REQ-019 SHALL discard in-flight writes when reset asserts mid-operation; first acceptance possible at first rising edge after rst_n rises.

Verification
REQ-020 SHALL verify: issue op_type=00 op_code=3 rd=5 at cycle 0 -> busy_s[5]=1 cycles 1..3, wb_we=1 wb_rd=5 cycle 3, busy_s[5]=0 cycle 4.
REQ-021 SHALL verify: op_type=00 op_code=12 rd=2 then next cycle op_type=00 op_code=1 rs1=2 rs_vec=1 -> stall=1 until busy_v[2] clears, then accepted; wb_we_v pulses once.
REQ-022 SHALL verify: rd=0 with op_code=3, and op_type=11 any rd -> accepted, no busy bit, no write strobe, pending_cnt unchanged.
REQ-023 SHALL verify: scalar load (10, code 0) rd=7 and vector load (10, code 15) rd=7 back-to-back -> both accepted (different files), wb_we cycle 3, wb_we_v cycle 4, pending_cnt peaks at 2.
REQ-024 SHALL verify: three writes in flight, flush asserted in writeback cycle of oldest -> oldest strobe still occurs, other two never write, busy all 0 and pending_cnt 0 one cycle later.
REQ-025 SHALL verify: rst_n low for one cycle with two writes in flight -> all outputs 0 immediately, no strobes after release.
